// File: rtl/sequenciador_instrucoes.sv
// Instruction sequencer: fetches words from a synchronous-read ROM, drives
// them onto the processor DIN with a one-cycle Run pulse and waits for Done.
// Ports:
//   Clock, Resetn       clock (rising edge) and asynchronous active-low reset
//   Start               level; begins execution at Pc=0 when not busy
//   Mem_addr, Mem_data  ROM address (comb) and read data (one cycle later)
//   Proc_DIN, Proc_Run  registered word and Run pulse to the processor
//   Proc_Done           processor completion, sampled only while waiting
//   Busy/Finished/Error status flags
//   Pc, Instr_count     program counter, saturating completed-instruction count
module sequenciador_instrucoes #(
  parameter int          ADDR_W    = 5,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 15,
  parameter logic [2:0]  OP_MVI    = 3'b001
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [15:0]       Mem_data,
  output logic [15:0]       Proc_DIN,
  output logic              Proc_Run,
  input  logic              Proc_Done,
  output logic              Busy,
  output logic              Finished,
  output logic              Error,
  output logic [ADDR_W-1:0] Pc,
  output logic [7:0]        Instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_din;
  logic              r_run;
  logic [7:0]        r_cnt;
  logic [3:0]        r_wd;

  logic w_stopped;
  logic w_go;
  logic w_halt;
  logic w_ld_mvi;
  logic w_is_mvi;
  logic w_timeout;

  assign w_stopped = (r_state == S_IDLE) ||
                     (r_state == S_FINISH) ||
                     (r_state == S_ERROR);
  assign w_go      = w_stopped && Start;
  assign w_halt    = (Mem_data == HALT_WORD);
  assign w_ld_mvi  = (Mem_data[8:6] == OP_MVI);
  // In ISSUE the instruction is still held in r_din.
  assign w_is_mvi  = (r_din[8:6] == OP_MVI);
  assign w_timeout = (r_wd == 4'(TIMEOUT));

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (Start) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = w_halt ? S_FINISH : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // Done has priority over the watchdog.
        if (Proc_Done)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy     = (r_state == S_FETCH) || (r_state == S_LOAD) ||
               (r_state == S_ISSUE) || (r_state == S_WAIT);
    Finished = (r_state == S_FINISH);
    Error    = (r_state == S_ERROR);
    // mvi prefetches its immediate so it is on Mem_data during ISSUE.
    Mem_addr = r_pc;
    if ((r_state == S_LOAD) && w_ld_mvi) Mem_addr = r_pc + 1'b1;
  end

  // Datapath
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc  <= '0;
      r_din <= '0;
      r_run <= 1'b0;
      r_cnt <= '0;
      r_wd  <= '0;
    end else begin
      r_run <= 1'b0;
      if (w_go) begin
        r_pc  <= '0;
        r_cnt <= '0;
      end
      if ((r_state == S_LOAD) && !w_halt) begin
        r_din <= Mem_data;
        r_run <= 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_wd <= '0;
        if (w_is_mvi) begin
          r_din <= Mem_data;
          r_pc  <= r_pc + ADDR_W'(2);
        end else begin
          r_pc  <= r_pc + ADDR_W'(1);
        end
      end
      if (r_state == S_WAIT) begin
        r_wd <= r_wd + 4'd1;
        if (Proc_Done && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign Proc_DIN    = r_din;
  assign Proc_Run    = r_run;
  assign Pc          = r_pc;
  assign Instr_count = r_cnt;

endmodule

// File: doc/sequenciador_instrucoes.md
Name: sequenciador_instrucoes

Overview:
Sequences a program stored in an external synchronous-read instruction memory into the multicycle processor. Per instruction it fetches the word, presents it on the processor DIN, and pulses Run. For mvi it supplies the immediate word in the following cycle. It then waits for Done. It sits between the instruction ROM and the processor's DIN/Run/Done pins, and provides start/halt, a timeout watchdog and an instruction counter.

Parameters:
ADDR_W, 5, instruction memory address width; PC wraps modulo 2^ADDR_W.
HALT_WORD, 16'hFFFF, word that ends the program when fetched as an instruction.
TIMEOUT, 15, max cycles in WAIT without Done before ERROR (4-bit watchdog counter).
OP_MVI, 3'b001, opcode value in instruction bits [8:6] that takes an immediate word.

Ports:
Clock  in  1  system clock, rising edge.
Resetn  in  1  asynchronous, active-low reset.
Start  in  1  level; sampled in IDLE/FINISH/ERROR to begin at PC=0.
Mem_addr  out  ADDR_W  instruction memory address (combinational from state/PC).
Mem_data  in  16  memory read data, valid the cycle after Mem_addr is presented.
Proc_DIN  out  16  registered word driven to the processor DIN.
Proc_Run  out  1  registered one-cycle Run pulse.
Proc_Done  in  1  processor Done; sampled only in WAIT.
Busy  out  1  high in FETCH/LOAD/ISSUE/WAIT.
Finished  out  1  high in FINISH.
Error  out  1  high in ERROR.
Pc  out  ADDR_W  current program counter.
Instr_count  out  8  instructions completed; saturates at 255.

Behaviour:
- Reset: state=IDLE; Pc=0, Proc_DIN=0, Proc_Run=0, Instr_count=0, watchdog=0; Busy/Finished/Error=0. Reset in any state aborts immediately. No pending Run is emitted after Resetn rises.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, FINISH, ERROR.
- IDLE/FINISH/ERROR: when Start=1, set Pc<=0 and Instr_count<=0 -> FETCH. Start is ignored while Busy.
- FETCH: Mem_addr=Pc -> LOAD.
- LOAD: Mem_data holds the instruction.
  - If Mem_data==HALT_WORD -> FINISH; no Run is issued and Pc stays at the halt address.
  - Otherwise Proc_DIN<=Mem_data -> ISSUE.
  - If Mem_data[8:6]==OP_MVI, Mem_addr=Pc+1 (immediate prefetch); otherwise Mem_addr=Pc.
- ISSUE: Proc_Run=1 for exactly this cycle, with Proc_DIN = the instruction.
  - mvi: Proc_DIN<=Mem_data, so the immediate is on DIN the next cycle; Pc<=Pc+2.
  - Other instructions: Pc<=Pc+1. Watchdog<=0.
  - -> WAIT.
- WAIT: Proc_Run=0 and Proc_DIN held; watchdog increments each cycle.
  - Proc_Done=1: Instr_count+1 (saturating), -> FETCH.
  - Else if watchdog==TIMEOUT: -> ERROR, with Pc pointing at the next instruction.
  - Done and timeout in the same cycle: Done wins.
- Pc arithmetic is modulo 2^ADDR_W. An mvi at the last address reads its immediate from address 0, and execution continues from address 1.
- An immediate word equal to HALT_WORD is data, never a halt.
- Issue latency: Start to Run pulse is 3 cycles (FETCH, LOAD, ISSUE). Done to the next Run is 3 cycles.

Test Plan:
- ROM {0:16'h0008 (mv), 1:FFFF}, Start pulse, processor Done 2 cycles after Run -> Run high at cycle 3 with DIN=0008; Finished=1, Instr_count=1, Pc=1.
- ROM {0:16'h0040 (mvi R1), 1:16'h00FF, 2:FFFF} -> DIN=0040 with Run, next cycle DIN=00FF; FINISH with Pc=2, Instr_count=1.
- ROM {0:mvi, 1:16'hFFFF, 2:FFFF} -> FFFF is taken as the immediate and the halt occurs at address 2; Instr_count=1.
- Proc_Done held 0 after Run -> Error=1 exactly 16 cycles after entering WAIT; Start again -> Pc=0, Error=0, Busy=1.
- Resetn pulled low in WAIT -> next edge all outputs at reset values. Start held high during WAIT -> no effect.
- ADDR_W=2, mvi at address 3, ROM[0]=imm, ROM[1]=FFFF -> immediate read from address 0, halt at Pc=1. Also 300 non-halt instructions -> Instr_count saturates at 255.
